mem_access_unit: RTL and testbench

- Initiator-side controller for the single-port synchronous word memory. It takes byte, halfword and word load/store requests from the core's load/store stage and drives the memory's mem_read/mem_write strobes.
- Sub-word stores are done as read-modify-write because the memory has no byte enables. Loads are extracted and sign/zero-extended.
- It guarantees the memory never sees read and write strobes in the same cycle.

---
 rtl/mem_access_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bundles the request, response and memory-side signals of mem_access_unit.
//   slave  : view used by mem_access_unit (accepts requests, drives the memory strobes)
//   master : view used by the core/memory side (issues requests, returns mem_rdata)
// Request:  req_valid/req_ready handshake with req_write, req_size, req_unsigned, req_addr,
//           req_wdata.
// Response: rsp_valid/rsp_ready handshake with rsp_rdata, rsp_err.
// Memory:   mem_read, mem_write, mem_address (word address), mem_wdata, mem_rdata.
interface mem_access_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-3:0] mem_address;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
           mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_address,
           mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
           mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_address,
           mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port synchronous word memory without byte enables.
// Byte/halfword stores are performed as read-modify-write; loads are lane-extracted and
// sign- or zero-extended. Read and write strobes are never asserted in the same cycle.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_access_if.slave (request, response and memory signals)
//   stat_*     : 16-bit saturating response counters, present only when the macro
//                MEM_ACCESS_STATS_EN is defined
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]  stat_loads,
  output logic [15:0]  stat_stores,
  output logic [15:0]  stat_errors
`endif
);

  if (WORD_WIDTH != 32) begin : gen_width_check
    $error("mem_access_unit supports WORD_WIDTH == 32 only");
  end

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic                  write_q, write_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-3:0] mem_address_q, mem_address_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  req_bad;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_val;
  logic [31:0]           merged;

  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Lane extraction and merge work on the word returned during StCap.
  always_comb begin
    byte_lane = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_lane = bus.mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   load_val = unsigned_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_val = unsigned_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_val = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    write_d       = write_q;
    addr_lo_d     = addr_lo_q;
    wdata_d       = wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          write_d    = bus.req_write;
          addr_lo_d  = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          if (req_bad) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (bus.req_write && bus.req_size == 2'b10) begin
            state_d       = StWr;
            mem_write_d   = 1'b1;
            mem_address_d = bus.req_addr[ADDR_WIDTH-1:2];
            mem_wdata_d   = bus.req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_d       = StRd;
            mem_read_d    = 1'b1;
            mem_address_d = bus.req_addr[ADDR_WIDTH-1:2];
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (write_q) begin
          state_d     = StWr;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_val;
        end
      end
      StWr: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      write_q       <= 1'b0;
      addr_lo_q     <= '0;
      wdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      write_q       <= write_d;
      addr_lo_q     <= addr_lo_d;
      wdata_q       <= wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;

`ifdef MEM_ACCESS_STATS_EN
  logic        rsp_fire;
  logic [15:0] loads_q, stores_q, errors_q;

  assign rsp_fire = (state_q == StResp) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else if (rsp_fire) begin
      if (rsp_err_q) begin
        if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
      end else if (write_q) begin
        if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
      end else begin
        if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural synchronous word memory and a
// reference memory image used to predict load results and store contents.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) bus();

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

  mem_access_unit #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
`endif
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_loads = 0, exp_stores = 0, exp_errs = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];

  // One complete transaction: predict, drive, observe strobes/latency, hold, handshake.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wd, input int hold);
    exp_t        e;
    exp_t        got_e;
    logic [31:0] word, new_word, mask, v;
    int          sh;
    logic        bad;
    int          lat, nrd, nwr;
    logic [31:0] held;

    bad  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    word = ref_mem[addr[11:2]];
    new_word = word;
    sh   = (sz == 2'b00) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    e.rdata = 32'h0;
    e.err   = bad;
    e.wr    = wr;
    if (bad) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (wr) begin
      new_word = (sz == 2'b10) ? wd : ((word & ~mask) | ((wd << sh) & mask));
      ref_mem[addr[11:2]] = new_word;
      if (sz == 2'b10) begin
        e.lat = 2; e.nrd = 0; e.nwr = 1;
      end else begin
        e.lat = 4; e.nrd = 1; e.nwr = 1;
      end
    end else begin
      e.lat = 3; e.nrd = 1; e.nwr = 0;
      if (sz == 2'b10) begin
        e.rdata = word;
      end else if (sz == 2'b00) begin
        v = (word >> sh) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        e.rdata = v;
      end else begin
        v = (word >> sh) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    sb_q.push_back(e);

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    lat = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
      check_val("strobe_overlap", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (bus.mem_read) begin
        nrd++;
        check_val("rd_address", 32'(bus.mem_address), 32'(addr[11:2]));
      end
      if (bus.mem_write) begin
        nwr++;
        check_val("wr_address", 32'(bus.mem_address), 32'(addr[11:2]));
        check_val("wr_wdata", bus.mem_wdata, new_word);
      end
    end while (!bus.rsp_valid && lat < 20);

    got_e = sb_q.pop_front();
    check_val("rsp_latency", lat, got_e.lat);
    check_val("num_reads", nrd, got_e.nrd);
    check_val("num_writes", nwr, got_e.nwr);
    check_val("rsp_rdata", bus.rsp_rdata, got_e.rdata);
    check_val("rsp_err", 32'(bus.rsp_err), 32'(got_e.err));

    held = bus.rsp_rdata;
    if (hold > 0) bus.req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("hold_rdata", bus.rsp_rdata, held);
      check_val("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check_val("hold_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("post_req_ready", 32'(bus.req_ready), 32'd1);
    if (got_e.err) exp_errs++;
    else if (got_e.wr) exp_stores++;
    else exp_loads++;
    if (wr && !bad) check_val("mem_content", mem[addr[11:2]], ref_mem[addr[11:2]]);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_flags", 32'({bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write}),
              32'd0);
    check_val("rst_rdata", bus.rsp_rdata, 32'd0);
    check_val("rst_address", 32'(bus.mem_address), 32'd0);
    check_val("rst_wdata", bus.mem_wdata, 32'd0);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;

    // Preload the first eight words through the unit.
    for (int i = 0; i < 8; i++) do_req(1'b1, 2'b10, 1'b0, 12'(i * 4), $urandom, 0);

    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 0);
    check_val("sw_word", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000_00A5, 0);
    check_val("sb_word", mem[4], 32'hDEAD_A5EF);
    do_req(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 12'h011, 32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5);
    do_req(1'b1, 2'b01, 1'b0, 12'h01E, 32'h1234_8001, 1);
    do_req(1'b0, 2'b01, 1'b1, 12'h01E, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)));
    end

    // Reset during the capture cycle of a byte store: nothing may reach memory.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 12'h010;
    bus.req_wdata = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check_val("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("arst_quiet", 32'({bus.rsp_valid, bus.mem_read, bus.mem_write}), 32'd0);
    end
    check_val("arst_mem", mem[4], ref_mem[4]);
    check_val("arst_req_ready", 32'(bus.req_ready), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0);

`ifdef MEM_ACCESS_STATS_EN
    // Counters were cleared by the mid-test reset; count only the final load.
    check_val("stat_loads", 32'(stat_loads), 32'd1);
    check_val("stat_stores", 32'(stat_stores), 32'd0);
    check_val("stat_errors", 32'(stat_errors), 32'd0);
    exp_loads = 0; exp_stores = 0; exp_errs = 0;
    do_req(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 12'h001, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 12'h004, 32'h1111_2222, 0);
    do_req(1'b1, 2'b00, 1'b0, 12'h005, 32'h33, 0);
    do_req(1'b0, 2'b10, 1'b0, 12'h002, 32'h0, 0);
    check_val("stat_loads3", 32'(stat_loads), 32'(exp_loads + 1));
    check_val("stat_stores2", 32'(stat_stores), 32'(exp_stores));
    check_val("stat_errors1", 32'(stat_errors), 32'(exp_errs));
`endif

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
